// File: rtl/fb_pixel_packer_if.sv
// Pixel-stream (valid/ready) and Avalon-MM write signals between renderer, packer and framebuffer.
// master = packer side, slave = stream source / memory side.
interface fb_pixel_packer_if #(
   parameter int unsigned ADDR_W = 15
) ();
   logic              pix_valid;
   logic              pix_ready;
   logic              pix_data;
   logic              pix_sof;
   logic [ADDR_W-1:0] fb_address;
   logic [31:0]       fb_writedata;
   logic              fb_write;
   logic              fb_waitrequest;

   modport master (
      input  pix_valid, pix_data, pix_sof, fb_waitrequest,
      output pix_ready, fb_address, fb_writedata, fb_write
   );

   modport slave (
      output pix_valid, pix_data, pix_sof, fb_waitrequest,
      input  pix_ready, fb_address, fb_writedata, fb_write
   );
endinterface

// File: rtl/fb_pixel_packer.sv
// Packs a raster-order 1-bpp pixel stream into 32-bit words and writes them to the framebuffer
// over Avalon-MM through a single-entry holding register; pulses frame_done after the last word.
module fb_pixel_packer #(
   parameter int unsigned H_PIXELS  = 640,
   parameter int unsigned V_LINES   = 480,
   parameter int unsigned ADDR_W    = 15,
   parameter int unsigned BASE_ADDR = 0
) (
   input  logic                 clk_i,
   input  logic                 reset_i,
   fb_pixel_packer_if.master    bus_io,
   output logic                 frame_done_o,
   output logic                 sync_err_o
);

   localparam int unsigned WORDS = (H_PIXELS * V_LINES) / 32;
   localparam int unsigned WordW = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [WordW-1:0] LastWord = WordW'(WORDS - 1);

   typedef enum logic [0:0] {StIdle, StPack} state_e;

   state_e            state_q;
   logic [31:0]       shift_q;
   logic [31:0]       shift_d;
   logic [4:0]        bitcnt_q;
   logic [WordW-1:0]  word_q;
   logic              hold_valid_q;
   logic              hold_last_q;
   logic [ADDR_W-1:0] hold_addr_q;
   logic [31:0]       hold_data_q;
   logic              frame_done_q;
   logic              sync_err_q;

   logic complete;
   logic stall;
   logic xfer;
   logic restart;
   logic word_end;

   always_comb begin
      complete = hold_valid_q & ~bus_io.fb_waitrequest;
      // Only the word-completing pixel needs the holding register, so only it can be stalled.
      stall    = (state_q == StPack) & (bitcnt_q == 5'd31) & hold_valid_q & bus_io.fb_waitrequest;
      xfer     = bus_io.pix_valid & ~reset_i & ~stall;
      restart  = xfer & bus_io.pix_sof;
      word_end = xfer & ~bus_io.pix_sof & (state_q == StPack) & (bitcnt_q == 5'd31);
      shift_d  = shift_q;
      shift_d[bitcnt_q] = bus_io.pix_data;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q      <= StIdle;
         shift_q      <= '0;
         bitcnt_q     <= '0;
         word_q       <= '0;
         hold_valid_q <= 1'b0;
         hold_last_q  <= 1'b0;
         hold_addr_q  <= '0;
         hold_data_q  <= '0;
         frame_done_q <= 1'b0;
         sync_err_q   <= 1'b0;
      end else begin
         frame_done_q <= complete & hold_last_q;
         sync_err_q   <= restart & (state_q == StPack);
         if (complete) begin
            hold_valid_q <= 1'b0;
         end
         if (restart) begin
            shift_q  <= {31'd0, bus_io.pix_data};
            bitcnt_q <= 5'd1;
            word_q   <= '0;
            state_q  <= StPack;
         end else if (xfer && (state_q == StPack)) begin
            bitcnt_q <= bitcnt_q + 5'd1;
            if (word_end) begin
               // Reload may coincide with completion of the previous write; this assignment wins.
               shift_q      <= '0;
               hold_valid_q <= 1'b1;
               hold_data_q  <= shift_d;
               hold_addr_q  <= ADDR_W'(BASE_ADDR) + ADDR_W'(word_q);
               hold_last_q  <= (word_q == LastWord);
               word_q       <= word_q + WordW'(1);
               if (word_q == LastWord) begin
                  state_q <= StIdle;
               end
            end else begin
               shift_q <= shift_d;
            end
         end
      end
   end

   assign bus_io.pix_ready    = ~reset_i & ~stall;
   assign bus_io.fb_write     = hold_valid_q;
   assign bus_io.fb_address   = hold_addr_q;
   assign bus_io.fb_writedata = hold_data_q;
   assign frame_done_o        = frame_done_q;
   assign sync_err_o          = sync_err_q;

endmodule

// File: tb/tb_fb_pixel_packer.sv
// Directed bench for fb_pixel_packer on a reduced 64x4 frame (8 words) at a non-zero base address.
module tb_fb_pixel_packer;

   localparam int unsigned HP    = 64;
   localparam int unsigned VL    = 4;
   localparam int unsigned AW    = 15;
   localparam int unsigned BASE  = 100;
   localparam int unsigned WORDS = 8;
   localparam int unsigned PIX   = 256;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic frame_done;
   logic sync_err;

   always #5 clk = ~clk;

   fb_pixel_packer_if #(.ADDR_W(AW)) bus ();

   fb_pixel_packer #(
      .H_PIXELS (HP),
      .V_LINES  (VL),
      .ADDR_W   (AW),
      .BASE_ADDR(BASE)
   ) dut (
      .clk_i       (clk),
      .reset_i     (reset),
      .bus_io      (bus.master),
      .frame_done_o(frame_done),
      .sync_err_o  (sync_err)
   );

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [31:0] wr_addr[$];
   logic [31:0] wr_data[$];
   int unsigned wr_cyc[$];
   int unsigned fd_n = 0;
   int unsigned fd_cyc = 0;
   int unsigned se_n = 0;

   always @(negedge clk) begin
      if (bus.fb_write && !bus.fb_waitrequest) begin
         wr_addr.push_back(32'(bus.fb_address));
         wr_data.push_back(bus.fb_writedata);
         wr_cyc.push_back(cyc);
      end
      if (frame_done) begin
         fd_n++;
         fd_cyc = cyc;
      end
      if (sync_err) se_n++;
   end

   int n_tot = 0;
   int n_bad = 0;
   int unsigned acc_n = 0;
   logic pre_write;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tot++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   function automatic logic pat(input int mode, input int p);
      logic [31:0] v;
      v = 32'(p);
      case (mode)
         0:       return v[0];
         1:       return v[1];
         default: return (p % 3) == 0;
      endcase
   endfunction

   task automatic send_px(input logic d, input logic s);
      logic rdy;
      int n;
      bus.pix_valid = 1'b1;
      bus.pix_data  = d;
      bus.pix_sof   = s;
      rdy = 1'b0;
      n = 0;
      while (!rdy && n < 200) begin
         @(negedge clk);
         rdy = bus.pix_ready;
         pre_write = bus.fb_write;
         @(posedge clk);
         #1;
         n++;
      end
      if (!rdy) chk("px_timeout", 32'd0, 32'd1);
      else acc_n++;
      bus.pix_valid = 1'b0;
      bus.pix_data  = 1'b0;
      bus.pix_sof   = 1'b0;
   endtask

   task automatic send_frame(input int mode);
      send_px(pat(mode, 0), 1'b1);
      for (int p = 1; p < int'(PIX); p++) send_px(pat(mode, p), 1'b0);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int n);
      bus.pix_valid = 1'b0;
      reset = 1'b1;
      repeat (n) @(posedge clk);
      #1;
      reset = 1'b0;
      acc_n = 0;
   endtask

   int unsigned w0, fd0, se0, stab_bad, drop_acc;
   logic [31:0] a0, d0;
   logic drop_seen;

   initial begin
      bus.pix_valid = 1'b0;
      bus.pix_data = 1'b0;
      bus.pix_sof = 1'b0;
      bus.fb_waitrequest = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", 32'(bus.pix_ready), 32'd0);
      chk("rst_write", 32'(bus.fb_write), 32'd0);
      chk("rst_addr", 32'(bus.fb_address), 32'd0);
      chk("rst_data", bus.fb_writedata, 32'd0);
      chk("rst_fdone", 32'(frame_done), 32'd0);
      chk("rst_serr", 32'(sync_err), 32'd0);
      do_reset(1);

      // Full frame, alternating pixels, no stalls
      w0 = wr_addr.size(); fd0 = fd_n; se0 = se_n;
      send_frame(0);
      idle(4);
      chk("t1_count", 32'(wr_addr.size() - w0), 32'(WORDS));
      for (int i = 0; i < int'(WORDS); i++) begin
         chk("t1_addr", wr_addr[w0 + i], 32'(BASE + i));
         chk("t1_data", wr_data[w0 + i], 32'hAAAAAAAA);
      end
      chk("t1_fdone", 32'(fd_n - fd0), 32'd1);
      chk("t1_fd_cyc", 32'(fd_cyc), 32'(wr_cyc[w0 + WORDS - 1] + 1));
      chk("t1_serr", 32'(se_n - se0), 32'd0);

      // First word latency and bit 0 placement
      do_reset(2);
      send_px(1'b1, 1'b1);
      for (int i = 0; i < 30; i++) send_px(1'b0, 1'b0);
      send_px(1'b0, 1'b0);
      chk("t2_pre_write", 32'(pre_write), 32'd0);
      @(negedge clk);
      chk("t2_write", 32'(bus.fb_write), 32'd1);
      chk("t2_addr", 32'(bus.fb_address), 32'(BASE));
      chk("t2_data", bus.fb_writedata, 32'h00000001);

      // Stalled write of word 0 while pixels keep arriving
      do_reset(2);
      bus.fb_waitrequest = 1'b1;
      w0 = wr_addr.size();
      stab_bad = 0; drop_seen = 1'b0; drop_acc = 0;
      fork
         begin
            for (int p = 0; p < 64; p++) send_px(pat(2, p), p == 0);
         end
         begin
            int n;
            n = 0;
            do begin
               @(negedge clk);
               n++;
            end while (!bus.fb_write && n < 300);
            chk("t3_wr_seen", 32'(bus.fb_write), 32'd1);
            a0 = 32'(bus.fb_address);
            d0 = bus.fb_writedata;
            repeat (40) begin
               @(negedge clk);
               if (bus.fb_write !== 1'b1 || 32'(bus.fb_address) !== a0 || bus.fb_writedata !== d0)
                  stab_bad++;
               if (!bus.pix_ready && bus.pix_valid && !drop_seen) begin
                  drop_seen = 1'b1;
                  drop_acc = acc_n;
               end
            end
            chk("t3_stable", 32'(stab_bad), 32'd0);
            chk("t3_addr0", a0, 32'(BASE));
            chk("t3_data0", d0, 32'h49249249);
            chk("t3_drop_seen", 32'(drop_seen), 32'd1);
            chk("t3_drop_at", 32'(drop_acc), 32'd63);
            @(posedge clk);
            #1;
            bus.fb_waitrequest = 1'b0;
            @(negedge clk);
            @(negedge clk);
            chk("t3_w1_write", 32'(bus.fb_write), 32'd1);
            chk("t3_w1_addr", 32'(bus.fb_address), 32'(BASE + 1));
            chk("t3_w1_data", bus.fb_writedata, 32'h92492492);
         end
      join
      idle(3);
      chk("t3_count", 32'(wr_addr.size() - w0), 32'd2);

      // Pixels without sof are discarded
      do_reset(2);
      w0 = wr_addr.size(); fd0 = fd_n;
      for (int i = 0; i < 100; i++) send_px(1'b1, 1'b0);
      idle(2);
      chk("t4_no_write", 32'(wr_addr.size() - w0), 32'd0);
      send_frame(1);
      idle(4);
      chk("t4_count", 32'(wr_addr.size() - w0), 32'(WORDS));
      chk("t4_addr0", wr_addr[w0], 32'(BASE));
      chk("t4_data0", wr_data[w0], 32'hCCCCCCCC);
      chk("t4_addr_last", wr_addr[w0 + WORDS - 1], 32'(BASE + WORDS - 1));
      chk("t4_fdone", 32'(fd_n - fd0), 32'd1);

      // Mid-frame sof restarts the frame
      do_reset(2);
      w0 = wr_addr.size(); fd0 = fd_n; se0 = se_n;
      send_px(pat(0, 0), 1'b1);
      for (int p = 1; p < 50; p++) send_px(pat(0, p), 1'b0);
      send_frame(1);
      idle(4);
      chk("t5_serr", 32'(se_n - se0), 32'd1);
      chk("t5_count", 32'(wr_addr.size() - w0), 32'(WORDS + 1));
      chk("t5_addr_a", wr_addr[w0], 32'(BASE));
      chk("t5_data_a", wr_data[w0], 32'hAAAAAAAA);
      chk("t5_addr_b", wr_addr[w0 + 1], 32'(BASE));
      chk("t5_data_b", wr_data[w0 + 1], 32'hCCCCCCCC);
      chk("t5_addr_last", wr_addr[w0 + WORDS], 32'(BASE + WORDS - 1));
      chk("t5_fdone", 32'(fd_n - fd0), 32'd1);

      // Reset during a stalled write
      do_reset(2);
      bus.fb_waitrequest = 1'b1;
      fd0 = fd_n;
      send_px(pat(0, 0), 1'b1);
      for (int p = 1; p < 40; p++) send_px(pat(0, p), 1'b0);
      @(negedge clk);
      chk("t6_stalled", 32'(bus.fb_write), 32'd1);
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      acc_n = 0;
      @(negedge clk);
      chk("t6_write_clr", 32'(bus.fb_write), 32'd0);
      chk("t6_addr_clr", 32'(bus.fb_address), 32'd0);
      bus.fb_waitrequest = 1'b0;
      idle(2);
      chk("t6_no_fdone", 32'(fd_n - fd0), 32'd0);
      w0 = wr_addr.size();
      send_frame(0);
      idle(4);
      chk("t6_count", 32'(wr_addr.size() - w0), 32'(WORDS));
      chk("t6_addr0", wr_addr[w0], 32'(BASE));
      chk("t6_data0", wr_data[w0], 32'hAAAAAAAA);
      chk("t6_fdone", 32'(fd_n - fd0), 32'd1);

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

endmodule
